// File: rtl/t06_direction_queue.sv
// Per-player direction input queue: button press edges become turn requests,
// filtered against the newest pending direction and applied one per game tick.
module t06_direction_queue #(
    parameter int         NUM_PLAYERS = 2,
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [1:0] RESET_DIR   = 2'b11,
    localparam int        CW          = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      tick,
    input  logic [NUM_PLAYERS-1:0]    btn_up,
    input  logic [NUM_PLAYERS-1:0]    btn_down,
    input  logic [NUM_PLAYERS-1:0]    btn_left,
    input  logic [NUM_PLAYERS-1:0]    btn_right,
    input  logic [NUM_PLAYERS-1:0]    bad_collision,
    output logic [2*NUM_PLAYERS-1:0]  direction_out,
    output logic [CW*NUM_PLAYERS-1:0] queue_count,
    output logic [NUM_PLAYERS-1:0]    overflow
);

    localparam int PW = $clog2(QUEUE_DEPTH);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_chan
        logic [3:0]    btn_now;
        logic [3:0]    btn_prev_q, btn_prev_d;
        logic [3:0]    rise;
        logic [1:0]    dir_q, dir_d;
        logic [1:0]    mem_q [QUEUE_DEPTH];
        logic [1:0]    mem_d [QUEUE_DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          ovf_q, ovf_d;
        logic          has_cand;
        logic [1:0]    cand;
        logic [1:0]    tail;
        logic          valid_turn;
        logic          full;
        logic          do_push;
        logic          do_pop;

        // bit order {left, down, right, up}
        assign btn_now = {btn_left[g], btn_down[g], btn_right[g], btn_up[g]};

        always_comb begin
            rise       = btn_now & ~btn_prev_q;
            btn_prev_d = btn_now;
            has_cand   = |rise;

            // later assignments win, giving up > right > down > left
            cand = DIR_LEFT;
            if (rise[2]) cand = DIR_DOWN;
            if (rise[1]) cand = DIR_RIGHT;
            if (rise[0]) cand = DIR_UP;

            tail       = (cnt_q != '0) ? mem_q[wr_ptr_q - PW'(1)] : dir_q;
            // a turn is useful only if it changes axis relative to the tail
            valid_turn = has_cand && (cand[1] != tail[1]);
            full       = (cnt_q == CW'(QUEUE_DEPTH));
            do_push    = valid_turn && !full;
            do_pop     = tick && (cnt_q != '0);

            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            dir_d    = dir_q;
            ovf_d    = valid_turn && full;

            if (do_push) begin
                mem_d[wr_ptr_q] = cand;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                dir_d    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);

            // collision restarts the channel but leaves button history tracking
            if (bad_collision[g]) begin
                dir_d    = RESET_DIR;
                cnt_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                ovf_d    = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
                btn_prev_q <= '0;
                dir_q      <= RESET_DIR;
                cnt_q      <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                ovf_q      <= 1'b0;
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    mem_q[i] <= DIR_UP;
                end
            end else begin
                btn_prev_q <= btn_prev_d;
                dir_q      <= dir_d;
                cnt_q      <= cnt_d;
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                ovf_q      <= ovf_d;
                mem_q      <= mem_d;
            end
        end

        assign direction_out[2*g +: 2] = dir_q;
        assign queue_count[CW*g +: CW] = cnt_q;
        assign overflow[g]             = ovf_q;
    end

endmodule

// File: tb/tb_t06_direction_queue.sv
// Self-checking bench for t06_direction_queue: a queue-based reference model is
// compared every cycle, plus hand-computed checks on directed scenarios.
module tb_t06_direction_queue;

    localparam int         NP        = 2;
    localparam int         DEPTH     = 4;
    localparam int         CW        = 3;
    localparam logic [1:0] RESET_DIR = 2'b11;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b11;

    logic              clk = 1'b0;
    logic              nrst = 1'b1;
    logic              tick = 1'b0;
    logic [NP-1:0]     btnUp = '0;
    logic [NP-1:0]     btnDown = '0;
    logic [NP-1:0]     btnLeft = '0;
    logic [NP-1:0]     btnRight = '0;
    logic [NP-1:0]     badCollision = '0;
    logic [2*NP-1:0]   directionOut;
    logic [CW*NP-1:0]  queueCount;
    logic [NP-1:0]     overflow;

    int compared = 0;
    int mismatched = 0;

    logic [1:0] modelQ [NP][$];
    logic [1:0] modelDir [NP];
    logic [3:0] modelPrev [NP];
    logic       modelOvf [NP];

    t06_direction_queue #(
        .NUM_PLAYERS(NP),
        .QUEUE_DEPTH(DEPTH),
        .RESET_DIR(RESET_DIR)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .tick(tick),
        .btn_up(btnUp),
        .btn_down(btnDown),
        .btn_left(btnLeft),
        .btn_right(btnRight),
        .bad_collision(badCollision),
        .direction_out(directionOut),
        .queue_count(queueCount),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NP; c++) begin
            modelQ[c].delete();
            modelDir[c]  = RESET_DIR;
            modelPrev[c] = 4'b0000;
            modelOvf[c]  = 1'b0;
        end
    endtask

    task automatic modelStep(input int c);
        logic [3:0] now;
        logic [3:0] rise;
        logic       hasCand;
        logic [1:0] cand;
        logic [1:0] tail;
        logic       popping;
        now  = {btnLeft[c], btnDown[c], btnRight[c], btnUp[c]};
        rise = now & ~modelPrev[c];
        modelPrev[c] = now;
        modelOvf[c]  = 1'b0;
        if (badCollision[c]) begin
            modelDir[c] = RESET_DIR;
            modelQ[c].delete();
            return;
        end
        hasCand = 1'b1;
        cand    = UP;
        if (rise[0])      cand = UP;
        else if (rise[1]) cand = RIGHT;
        else if (rise[2]) cand = DOWN;
        else if (rise[3]) cand = LEFT;
        else              hasCand = 1'b0;
        tail    = (modelQ[c].size() > 0) ? modelQ[c][$] : modelDir[c];
        popping = tick && (modelQ[c].size() > 0);
        if (hasCand && cand != tail && cand != opposite(tail)) begin
            if (modelQ[c].size() == DEPTH) modelOvf[c] = 1'b1;
            else modelQ[c].push_back(cand);
        end
        if (popping) modelDir[c] = modelQ[c].pop_front();
    endtask

    always @(posedge clk or posedge nrst) begin
        if (nrst) modelReset();
        else for (int c = 0; c < NP; c++) modelStep(c);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < NP; c++) begin
            checkOutput($sformatf("model_dir_ch%0d", c), int'(directionOut[2*c +: 2]), int'(modelDir[c]));
            checkOutput($sformatf("model_count_ch%0d", c), int'(queueCount[CW*c +: CW]), modelQ[c].size());
            checkOutput($sformatf("model_ovf_ch%0d", c), int'(overflow[c]), int'(modelOvf[c]));
        end
    end

    task automatic applyStimulus(input logic [NP-1:0] up, input logic [NP-1:0] dn,
                                 input logic [NP-1:0] lf, input logic [NP-1:0] rt,
                                 input logic t, input logic [NP-1:0] coll);
        btnUp        = up;
        btnDown      = dn;
        btnLeft      = lf;
        btnRight     = rt;
        tick         = t;
        badCollision = coll;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus('0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic pressDir(input int ch, input logic [1:0] d);
        logic [NP-1:0] m;
        m = NP'(1) << ch;
        case (d)
            UP:      applyStimulus(m, '0, '0, '0, 1'b0, '0);
            DOWN:    applyStimulus('0, m, '0, '0, 1'b0, '0);
            LEFT:    applyStimulus('0, '0, m, '0, 1'b0, '0);
            default: applyStimulus('0, '0, '0, m, 1'b0, '0);
        endcase
        idle();
    endtask

    task automatic doTick();
        applyStimulus('0, '0, '0, '0, 1'b1, '0);
        idle();
    endtask

    initial begin
        logic [1:0] expSeq [5];
        expSeq = '{UP, LEFT, DOWN, RIGHT, RIGHT};

        repeat (2) @(negedge clk);
        checkOutput("reset_dir", int'(directionOut), 4'hF);
        checkOutput("reset_count", int'(queueCount), 0);
        checkOutput("reset_ovf", int'(overflow), 0);
        #1 nrst = 1'b0;

        // up queued, down rejected as reverse of queued up
        pressDir(0, UP);
        checkOutput("first_press_count", int'(queueCount[2:0]), 1);
        pressDir(0, DOWN);
        checkOutput("reverse_reject_count", int'(queueCount[2:0]), 1);
        doTick();
        checkOutput("tick_up_dir", int'(directionOut[1:0]), int'(UP));
        checkOutput("tick_up_count", int'(queueCount[2:0]), 0);

        // collision restores right; same and reverse turns dropped
        applyStimulus('0, '0, '0, '0, 1'b0, 2'b01);
        idle();
        checkOutput("coll_dir", int'(directionOut[1:0]), int'(RIGHT));
        pressDir(0, RIGHT);
        applyStimulus('0, '0, 2'b01, '0, 1'b0, '0);
        checkOutput("left_reject_ovf", int'(overflow[0]), 0);
        idle();
        checkOutput("same_rev_count", int'(queueCount[2:0]), 0);
        checkOutput("same_rev_dir", int'(directionOut[1:0]), int'(RIGHT));

        // fill queue and overflow on the fifth turn
        pressDir(0, UP);
        pressDir(0, LEFT);
        pressDir(0, DOWN);
        pressDir(0, RIGHT);
        checkOutput("full_count", int'(queueCount[2:0]), 4);
        applyStimulus(2'b01, '0, '0, '0, 1'b0, '0);
        checkOutput("ovf_pulse", int'(overflow[0]), 1);
        checkOutput("ovf_count", int'(queueCount[2:0]), 4);
        idle();
        checkOutput("ovf_one_cycle", int'(overflow[0]), 0);
        for (int i = 0; i < 5; i++) begin
            doTick();
            checkOutput($sformatf("drain_dir_%0d", i), int'(directionOut[1:0]), int'(expSeq[i]));
        end
        checkOutput("drain_count", int'(queueCount[2:0]), 0);

        // push and pop in the same cycle
        pressDir(0, UP);
        applyStimulus('0, '0, 2'b01, '0, 1'b1, '0);
        checkOutput("pushpop_dir", int'(directionOut[1:0]), int'(UP));
        checkOutput("pushpop_count", int'(queueCount[2:0]), 1);
        idle();
        doTick();
        checkOutput("pushpop_next_dir", int'(directionOut[1:0]), int'(LEFT));

        // collision on ch1 overrides tick and press; ch0 untouched
        pressDir(1, UP);
        pressDir(1, LEFT);
        pressDir(1, DOWN);
        checkOutput("ch1_count3", int'(queueCount[5:3]), 3);
        applyStimulus('0, '0, '0, 2'b10, 1'b1, 2'b10);
        checkOutput("ch1_coll_dir", int'(directionOut[3:2]), int'(RIGHT));
        checkOutput("ch1_coll_count", int'(queueCount[5:3]), 0);
        checkOutput("ch0_kept_dir", int'(directionOut[1:0]), int'(LEFT));
        checkOutput("ch0_kept_count", int'(queueCount[2:0]), 0);
        applyStimulus('0, '0, '0, 2'b10, 1'b0, '0);
        checkOutput("held_no_retrigger", int'(queueCount[5:3]), 0);
        idle();

        // same-cycle priority resolution on ch1
        applyStimulus(2'b10, 2'b10, 2'b10, '0, 1'b0, '0);
        idle();
        doTick();
        checkOutput("prio_up", int'(directionOut[3:2]), int'(UP));
        applyStimulus('0, 2'b10, 2'b10, 2'b10, 1'b0, '0);
        idle();
        doTick();
        checkOutput("prio_right", int'(directionOut[3:2]), int'(RIGHT));
        applyStimulus('0, 2'b10, 2'b10, '0, 1'b0, '0);
        idle();
        doTick();
        checkOutput("prio_down", int'(directionOut[3:2]), int'(DOWN));

        // asynchronous reset between edges with two turns pending
        pressDir(0, UP);
        pressDir(0, RIGHT);
        checkOutput("pre_reset_count", int'(queueCount[2:0]), 2);
        @(posedge clk);
        #2 nrst = 1'b1;
        #1;
        checkOutput("async_reset_dir", int'(directionOut), 4'hF);
        checkOutput("async_reset_count", int'(queueCount), 0);
        @(negedge clk);
        #1 nrst = 1'b0;
        doTick();
        checkOutput("post_reset_tick_dir", int'(directionOut[1:0]), int'(RESET_DIR));
        checkOutput("post_reset_tick_count", int'(queueCount[2:0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/t06_direction_queue.md
T06_DIRECTION_QUEUE -- requirements
Module: t06_direction_queue

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of independent direction channels (1..4).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, pending turns buffered per channel (power of 2, 2..8).
REQ-003 SHALL have parameter RESET_DIR, default 2'b11, direction loaded on reset and on collision.
REQ-004 Encoding SHALL be 00 up, 01 down, 10 left, 11 right; reverse pairs are 00/01 and 10/11.
REQ-005 CW SHALL denote $clog2(QUEUE_DEPTH+1).
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 nrst  input  1  reset, asynchronous, active-high.
REQ-008 tick  input  1  game-step strobe, one cycle wide; applies queued turns.
REQ-009 btn_up  input  NUM_PLAYERS  up button per channel, level, synchronised upstream.
REQ-010 btn_down  input  NUM_PLAYERS  down button per channel.
REQ-011 btn_left  input  NUM_PLAYERS  left button per channel.
REQ-012 btn_right  input  NUM_PLAYERS  right button per channel.
REQ-013 bad_collision  input  NUM_PLAYERS  per-channel collision; restarts that channel.
REQ-014 direction_out  output  2*NUM_PLAYERS  registered current direction, channel i at [2i+1:2i].
REQ-015 queue_count  output  CW*NUM_PLAYERS  registered occupancy per channel.
REQ-016 overflow  output  NUM_PLAYERS  one-cycle pulse when a valid turn is dropped on a full queue.

Function
REQ-017 Channels SHALL be fully independent; no state or input shared except clk, nrst, tick.
REQ-018 Each button SHALL be registered; a press event is a rising edge (current 1, previous 0) on any of the four buttons.
REQ-019 Same-cycle multiple rising edges SHALL resolve by priority up > right > down > left to one candidate direction.
REQ-020 Held buttons SHALL generate no further events until released and re-pressed.
REQ-021 Tail direction SHALL be the newest queue entry if queue non-empty, else direction_out.
REQ-022 A candidate equal to tail or the reverse of tail SHALL be discarded, no count change, no overflow.
REQ-023 A valid candidate SHALL be written to the queue the cycle after the edge is sampled if count < QUEUE_DEPTH; count increments.
REQ-024 A valid candidate with count == QUEUE_DEPTH SHALL be discarded and overflow asserted for exactly the next cycle.
REQ-025 On tick with count > 0, head entry SHALL load direction_out the next cycle and count decrements.
REQ-026 On tick with count == 0, direction_out SHALL hold.
REQ-027 Push and pop in the same cycle SHALL both occur; count unchanged; tail evaluated before the pop.
REQ-028 A turn pushed in a tick cycle into an empty queue SHALL NOT apply until the following tick (minimum latency: one tick).
REQ-029 Queue pointers SHALL wrap modulo QUEUE_DEPTH; count SHALL never exceed QUEUE_DEPTH nor underflow.
REQ-030 bad_collision[i] SHALL override tick and push for channel i: next cycle direction_out = RESET_DIR, count = 0, pointers = 0, press discarded, overflow 0.
REQ-031 Button history registers SHALL keep updating during bad_collision so held buttons do not retrigger afterwards.

Reset
REQ-032 While nrst high, every channel SHALL force direction_out = RESET_DIR, queue_count = 0, pointers = 0, overflow = 0, button history = 0, independent of clk.
REQ-033 After nrst falls, first press event SHALL be accepted on the first rising clk edge that samples it.
REQ-034 Reset mid-operation SHALL discard all queued turns with no partial update.

Verification
REQ-035 Reset, ch0 presses up, down (separate edges), no tick -> count0 = 1 (down rejected as reverse of queued up); tick -> direction_out[1:0] = 00, count0 = 0.
REQ-036 Direction right, press right then left -> both discarded, count = 0, overflow 0; direction stays 11.
REQ-037 QUEUE_DEPTH=4: press up, left, down, right, up (no tick) -> count = 4, overflow pulses once on 5th; four ticks yield 00,10,01,11 in order, fifth tick holds 11.
REQ-038 Queue holds 1 entry; press and tick same cycle -> count stays 1, direction_out = old head, new entry applied on next tick.
REQ-039 Count = 3 on ch1, bad_collision[1] with simultaneous tick and press -> ch1 direction 11, count 0; ch0 state unchanged.
REQ-040 nrst asserted asynchronously between clk edges with count = 2 -> outputs reset immediately; after release, first tick leaves direction_out = RESET_DIR.
